// File: rtl/edge_det_pkg.sv
// Shared constants for the multi-channel edge detector: mode encodings and
// synchroniser depth limits.
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Wide enough to hold SYNC_STAGES_MAX + 1.
    localparam int unsigned WARM_W = 3;

endpackage

// File: rtl/edge_det_channel.sv
// One edge-detector channel: synchroniser, history flop, mode-selected edge
// decode, registered pulse, sticky flag and saturating event counter.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             cnt_clr,
    output logic             pulse,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   evt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        evt = 1'b0;
        unique case (mode)
            MODE_OFF:  evt = 1'b0;
            MODE_RISE: evt = rise;
            MODE_FALL: evt = fall;
            MODE_BOTH: evt = rise | fall;
            default:   evt = 1'b0;
        endcase
        // Warm-up gate; prev still tracks s so no stale edge survives it.
        evt = evt & arm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= s;
            pulse  <= evt;

            if (evt) begin
                sticky <= 1'b1;
            end else if (clr) begin
                sticky <= 1'b0;
            end

            // A clear colliding with an event keeps that event in the count.
            if (cnt_clr) begin
                cnt <= evt ? CNT_W'(1) : '0;
            end else if (evt && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent edge-detector channels sharing a post-reset warm-up gate,
// with an aggregated interrupt formed from the sticky flags.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       din,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       clr,
    input  logic [N_CH-1:0]       cnt_clr,
    output logic [N_CH-1:0]       pulse,
    output logic [N_CH-1:0]       sticky,
    output logic [N_CH*CNT_W-1:0] cnt,
    output logic                  irq
);

    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

    logic [WARM_W-1:0] warm_q;
    logic              arm;

    // Events stay blocked until the synchronisers and prev hold real input data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_q <= WARM_LOAD;
        end else if (warm_q != '0) begin
            warm_q <= warm_q - WARM_W'(1);
        end
    end

    assign arm = (warm_q == '0);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .arm     (arm),
            .din     (din[i]),
            .mode    (mode[2*i +: 2]),
            .clr     (clr[i]),
            .cnt_clr (cnt_clr[i]),
            .pulse   (pulse[i]),
            .sticky  (sticky[i]),
            .cnt     (cnt[CNT_W*i +: CNT_W])
        );
    end

    assign irq = |sticky;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random traffic, all
// checked every cycle against a history-based reference model.
module tb_multi_edge_detector;

    localparam int N_CH  = 8;
    localparam int S     = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH-1:0]       din = '0;
    logic [2*N_CH-1:0]     mode = '0;
    logic [N_CH-1:0]       clr = '0;
    logic [N_CH-1:0]       cnt_clr = '0;
    logic [N_CH-1:0]       pulse;
    logic [N_CH-1:0]       sticky;
    logic [N_CH*CNT_W-1:0] cnt;
    logic                  irq;

    multi_edge_detector #(
        .N_CH        (N_CH),
        .SYNC_STAGES (S),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .mode    (mode),
        .clr     (clr),
        .cnt_clr (cnt_clr),
        .pulse   (pulse),
        .sticky  (sticky),
        .cnt     (cnt),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: din as sampled at each edge since reset release.
    logic [N_CH-1:0] dhist[$];
    int              t;
    logic [N_CH-1:0] pulse_m;
    logic [N_CH-1:0] sticky_m;
    int              cnt_m[N_CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N_CH-1:0] hist(input int j);
        if (j < 1) return '0;
        return dhist[j-1];
    endfunction

    task automatic model_clear();
        dhist.delete();
        t        = 0;
        pulse_m  = '0;
        sticky_m = '0;
        for (int i = 0; i < N_CH; i++) cnt_m[i] = 0;
    endtask

    // Edge at t reflects the input change between samples t-S-1 and t-S.
    task automatic model_edge();
        logic [N_CH-1:0] cur, old;
        logic            ev;
        t++;
        dhist.push_back(din);
        cur = hist(t - S);
        old = hist(t - S - 1);
        for (int i = 0; i < N_CH; i++) begin
            ev = (t >= S + 2) && (cur[i] != old[i]) && (cur[i] ? mode[2*i] : mode[2*i+1]);
            pulse_m[i] = ev;
            if (ev) sticky_m[i] = 1'b1;
            else if (clr[i]) sticky_m[i] = 1'b0;
            if (cnt_clr[i]) cnt_m[i] = ev ? 1 : 0;
            else if (ev && cnt_m[i] < CMAX) cnt_m[i] = cnt_m[i] + 1;
        end
    endtask

    task automatic compare_all();
        logic [N_CH*CNT_W-1:0] exp_cnt;
        for (int i = 0; i < N_CH; i++) exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(cnt_m[i]);
        check("pulse", 64'(pulse), 64'(pulse_m));
        check("sticky", 64'(sticky), 64'(sticky_m));
        check("irq", 64'(irq), 64'(|sticky_m));
        check("cnt", 64'(cnt), 64'(exp_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Called away from a clock edge; outputs must clear without any edge.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_clear();
        check("rst_pulse", 64'(pulse), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [N_CH*CNT_W-1:0] all5;
        for (int i = 0; i < N_CH; i++) all5[i*CNT_W +: CNT_W] = CNT_W'(5);

        // Warm-up: input high through reset must not register a rise.
        din  = 8'hFF;
        mode = 16'h5555;
        #2;
        apply_reset();
        repeat (20) step();
        check("warm_sticky", 64'(sticky), 64'd0);
        check("warm_cnt", 64'(cnt), 64'd0);

        // Channel 0 rise then fall in rise mode.
        din = 8'h00;
        repeat (5) step();
        din = 8'h01;
        repeat (4) step();
        check("ch0_sticky", 64'(sticky[0]), 64'd1);
        check("ch0_cnt", 64'(cnt[0 +: CNT_W]), 64'd1);
        check("ch0_irq", 64'(irq), 64'd1);
        din = 8'h00;
        repeat (5) step();
        clr = '1;
        step();
        clr = '0;

        // Channel 3 both-edge toggling every cycle.
        mode    = 16'h00C0;
        cnt_clr = 8'h08;
        step();
        cnt_clr = '0;
        for (int k = 0; k < 10; k++) begin
            din[3] = ~din[3];
            step();
        end
        repeat (4) step();
        check("ch3_cnt", 64'(cnt[3*CNT_W +: CNT_W]), 64'd10);

        // Channel 1 saturation, then clear collisions.
        mode = 16'h0004;
        for (int k = 0; k < 40; k++) begin
            din[1] = ~din[1];
            step();
        end
        repeat (4) step();
        check("ch1_sat", 64'(cnt[1*CNT_W +: CNT_W]), 64'(CMAX));
        din[1] = 1'b1;
        step();
        step();
        cnt_clr = 8'h02;
        clr     = 8'h02;
        step();
        check("ch1_cntclr_evt", 64'(cnt[1*CNT_W +: CNT_W]), 64'd1);
        check("ch1_clr_evt", 64'(sticky[1]), 64'd1);
        cnt_clr = '0;
        step();
        check("ch1_clr_noevt", 64'(sticky[1]), 64'd0);
        clr = '0;

        // Mode off, then enable on a steady-high line, then a real rise.
        mode = '0;
        for (int k = 0; k < 6; k++) begin
            din = ~din;
            step();
        end
        din = 8'hFF;
        repeat (4) step();
        mode = 16'h5555;
        repeat (4) step();
        check("enable_steady", 64'(pulse), 64'd0);
        din = 8'hFB;
        repeat (4) step();
        din = 8'hFF;
        repeat (4) step();

        // Every channel to count 5, then reset mid-operation.
        clr     = '1;
        cnt_clr = '1;
        step();
        clr     = '0;
        cnt_clr = '0;
        din     = '0;
        step();
        for (int k = 0; k < 5; k++) begin
            din = 8'hFF;
            step();
            din = 8'h00;
            step();
        end
        repeat (3) step();
        check("all_cnt5", 64'(cnt), 64'(all5));
        apply_reset();
        din = 8'hFF;
        step();
        din = 8'h00;
        step();
        din = 8'hFF;
        step();
        check("post_rst_warm", 64'(pulse), 64'd0);
        repeat (6) step();

        // Random traffic with an occasional reset.
        for (int k = 0; k < 400; k++) begin
            din     = 8'($urandom());
            mode    = 16'($urandom());
            clr     = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'h00;
            cnt_clr = ($urandom_range(0, 15) == 0) ? 8'($urandom()) : 8'h00;
            if (k == 200) apply_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
